// File: rtl/jogo_unidade_controle_pkg.sv
// Shared state codes, level codes and LFSR step for the game control unit.
package jogo_unidade_controle_pkg;

  typedef enum logic [2:0] {
    ST_INICIAL   = 3'd0,
    ST_PREPARA   = 3'd1,
    ST_NOVO_ALVO = 3'd2,
    ST_JOGANDO   = 3'd3,
    ST_FIM       = 3'd4
  } estado_t;

  localparam logic [1:0] NIVEL_0 = 2'd0;
  localparam logic [1:0] NIVEL_1 = 2'd1;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/jogo_unidade_controle_lfsr_alvo.sv
// Free-running LFSR plus target pick that never repeats the current LED.
module jogo_unidade_controle_lfsr_alvo
  import jogo_unidade_controle_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] atual,
  output logic [2:0] novo
);

  localparam logic [3:0] NUM_LEDS_W = 4'(NUM_LEDS);
  localparam logic [2:0] ULTIMO_LED = 3'(NUM_LEDS - 1);

  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] cand;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  // Fold out-of-range codes back once, then step past the current LED on a collision
  always_comb begin
    cand = lfsr_q[2:0];
    if ({1'b0, cand} >= NUM_LEDS_W) cand = 3'({1'b0, cand} - NUM_LEDS_W);
    novo = cand;
    if (cand == atual) novo = (atual == ULTIMO_LED) ? 3'd0 : atual + 3'd1;
  end

endmodule

// File: rtl/jogo_unidade_controle.sv
// Game control FSM: sequences a round, drives per-level count/clear strobes,
// target LED and game timer, and ends the game on win score or timeout.
module jogo_unidade_controle
  import jogo_unidade_controle_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 8,
  parameter int unsigned PONTOS_VITORIA = 20,
  parameter logic [15:0] TEMPO_JOGO     = 16'd60000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        tick,
  input  logic [1:0]  nivel_dificuldade,
  input  logic        ganhou_ponto,
  input  logic        perdeu_ponto,
  input  logic [9:0]  pontuacao,
  output logic [1:0]  nivel_ativo,
  output logic [2:0]  position_led,
  output logic        conta_nivel0,
  output logic        conta_nivel1,
  output logic        conta_nivel23,
  output logic        reset_ponto,
  output logic        reset_nivel0,
  output logic        reset_nivel1,
  output logic        reset_nivel23,
  output logic [15:0] tempo_restante,
  output logic        fim_jogo,
  output logic        venceu,
  output logic [2:0]  estado
);

  localparam logic [9:0] PONTOS_V = 10'(PONTOS_VITORIA);

  estado_t     state_q, state_d;
  logic [1:0]  nivel_q, nivel_d;
  logic [2:0]  pos_q, pos_d;
  logic [15:0] tempo_q, tempo_d;
  logic        fim_q, fim_d;
  logic        venceu_q, venceu_d;
  logic [2:0]  novo_alvo;
  logic        evento, sel_conta, sel_reset, reset_todos;

  jogo_unidade_controle_lfsr_alvo #(
    .NUM_LEDS  (NUM_LEDS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr_alvo (
    .clock (clock),
    .reset (reset),
    .atual (pos_q),
    .novo  (novo_alvo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_INICIAL;
      nivel_q  <= 2'd0;
      pos_q    <= 3'd0;
      tempo_q  <= 16'd0;
      fim_q    <= 1'b0;
      venceu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      nivel_q  <= nivel_d;
      pos_q    <= pos_d;
      tempo_q  <= tempo_d;
      fim_q    <= fim_d;
      venceu_q <= venceu_d;
    end
  end

  // A point event clears the active level counter in the same cycle, even when the game ends
  always_comb begin
    state_d     = state_q;
    nivel_d     = nivel_q;
    pos_d       = pos_q;
    tempo_d     = tempo_q;
    fim_d       = fim_q;
    venceu_d    = venceu_q;
    evento      = ganhou_ponto | perdeu_ponto;
    sel_conta   = 1'b0;
    sel_reset   = 1'b0;
    reset_todos = 1'b0;
    reset_ponto = 1'b0;

    case (state_q)
      ST_INICIAL: if (iniciar) state_d = ST_PREPARA;
      ST_PREPARA: begin
        reset_ponto = 1'b1;
        reset_todos = 1'b1;
        nivel_d     = nivel_dificuldade;
        tempo_d     = TEMPO_JOGO;
        fim_d       = 1'b0;
        venceu_d    = 1'b0;
        state_d     = ST_NOVO_ALVO;
      end
      ST_NOVO_ALVO: begin
        pos_d     = novo_alvo;
        sel_reset = 1'b1;
        state_d   = ST_JOGANDO;
      end
      ST_JOGANDO: begin
        sel_conta = tick & ~evento;
        sel_reset = evento;
        if (tick && tempo_q != 16'd0) tempo_d = tempo_q - 16'd1;
        if (pontuacao >= PONTOS_V) begin
          state_d  = ST_FIM;
          fim_d    = 1'b1;
          venceu_d = 1'b1;
        end else if (tempo_q == 16'd0) begin
          state_d  = ST_FIM;
          fim_d    = 1'b1;
          venceu_d = 1'b0;
        end else if (evento) begin
          state_d = ST_NOVO_ALVO;
        end
      end
      ST_FIM:  if (iniciar) state_d = ST_PREPARA;
      default: state_d = ST_INICIAL;
    endcase

    conta_nivel0  = sel_conta && (nivel_q == NIVEL_0);
    conta_nivel1  = sel_conta && (nivel_q == NIVEL_1);
    conta_nivel23 = sel_conta && nivel_q[1];
    reset_nivel0  = reset_todos | (sel_reset && (nivel_q == NIVEL_0));
    reset_nivel1  = reset_todos | (sel_reset && (nivel_q == NIVEL_1));
    reset_nivel23 = reset_todos | (sel_reset && nivel_q[1]);
  end

  assign nivel_ativo    = nivel_q;
  assign position_led   = pos_q;
  assign tempo_restante = tempo_q;
  assign fim_jogo       = fim_q;
  assign venceu         = venceu_q;
  assign estado         = state_q;

endmodule
